// File: rtl/hilo_div_pkg.sv
// Shared types and constants for the HI/LO multi-cycle divider.
package hilo_div_pkg;

  // Divider FSM encoding; the values match the DIV_IDLE/DIV_CALC/DIV_DONE constants.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } div_state_e;

  localparam int unsigned DefaultWidth = 32;

endpackage

// File: rtl/hilo_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] rem_i,
  input  logic [Width-1:0] quo_i,
  input  logic [Width-1:0] div_i,
  output logic [Width-1:0] rem_o,
  output logic [Width-1:0] quo_o
);

  logic [Width:0] shifted;
  logic [Width:0] diff;
  logic           no_borrow;

  // Shifted remainder needs one extra bit since it can reach 2*divisor-1.
  always_comb begin
    shifted   = {rem_i, quo_i[Width-1]};
    diff      = shifted - {1'b0, div_i};
    no_borrow = ~diff[Width];
    rem_o     = no_borrow ? diff[Width-1:0] : shifted[Width-1:0];
    quo_o     = {quo_i[Width-2:0], no_borrow};
  end

endmodule

// File: rtl/hilo_div.sv
// Multi-cycle DIV/DIVU unit: remainder to HI, quotient to LO, one quotient bit per cycle.
module hilo_div
  import hilo_div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic               qsign_q, qsign_d;
  logic               rsign_q, rsign_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH-1:0]   step_rem, step_quo;
  logic [WIDTH-1:0]   rem_fix, quo_fix;

  div_step #(
    .Width (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Operand magnitudes; |0x80000000| wraps to itself, which is the right unsigned value.
  always_comb begin
    a_abs = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_abs = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // Sign correction applied to the outcome of the final iteration.
  always_comb begin
    rem_fix = rsign_q ? (~step_rem + 1'b1) : step_rem;
    quo_fix = qsign_q ? (~step_quo + 1'b1) : step_quo;
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start && !annul) begin
          if (b == '0) begin
            // Divide by zero skips CALC: HI gets the dividend, LO all-ones.
            state_d  = StDone;
            result_d = {a, {WIDTH{1'b1}}};
          end else begin
            state_d = StCalc;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = a_abs;
            div_d   = b_abs;
            qsign_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            rsign_d = signed_div & a[WIDTH-1];
          end
        end
      end
      StCalc: begin
        if (annul) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            // Result is latched on entry to DONE so it is valid alongside ready.
            state_d  = StDone;
            cnt_d    = '0;
            result_d = {rem_fix, quo_fix};
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StDone);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_hilo_div.sv
// Directed self-checking bench for hilo_div.
module tb_hilo_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        ready;
  logic [63:0] result;

  int errors;
  int checks;

  hilo_div #(
    .WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .ready      (ready),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives a one-cycle start; returns at the negedge of cycle 1 (launch edge = cycle 0).
  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic sg);
    @(negedge clk);
    start = 1'b1; a = av; b = bv; signed_div = sg;
    @(negedge clk);
    start = 1'b0; a = 32'hDEADBEEF; b = 32'h0BADF00D; signed_div = ~sg;
  endtask

  // Steps cycles until ready (bounded); reports the cycle it was seen and any busy gap.
  task automatic wait_ready(input int first, output int cyc, output bit gap);
    cyc = first;
    gap = 1'b0;
    while (!ready && cyc < 60) begin
      if (!busy) gap = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (!busy) gap = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", ready); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got=%h want=0", result); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu_basic;
    int cyc; bit gap;
    launch(32'd7, 32'd2, 1'b0);
    wait_ready(1, cyc, gap);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL divu7_2_ready_cycle got=%0d want=33", cyc); end
    checks++; if (gap !== 1'b0) begin errors++; $display("FAIL divu7_2_busy_gap got=%b want=0", gap); end
    checks++; if (result !== {32'h1, 32'h3}) begin
      errors++; $display("FAIL divu7_2_result got=%h want=%h", result, {32'h1, 32'h3});
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL divu7_2_idle34 got busy=%b ready=%b want 0 0", busy, ready);
    end
    checks++; if (result !== {32'h1, 32'h3}) begin
      errors++; $display("FAIL divu7_2_hold got=%h want=%h", result, {32'h1, 32'h3});
    end
  endtask

  task automatic test_signed;
    logic [31:0] ta [4] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] tb [4] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd2};
    logic        ts [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0] te [4] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'h00000001, 32'hFFFFFFFD},
                            {32'hFFFFFFFF, 32'h00000003}, {32'h00000001, 32'h7FFFFFFC}};
    int cyc; bit gap;
    for (int i = 0; i < 4; i++) begin
      launch(ta[i], tb[i], ts[i]);
      wait_ready(1, cyc, gap);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL signed[%0d]_cycle got=%0d want=33", i, cyc); end
      checks++; if (result !== te[i]) begin
        errors++; $display("FAIL signed[%0d]_result got=%h want=%h", i, result, te[i]);
      end
    end
  endtask

  task automatic test_extremes;
    logic [31:0] ta [4] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'd5};
    logic [31:0] tb [4] = '{32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7};
    logic        ts [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] te [4] = '{{32'h0, 32'hFFFFFFFF}, {32'h0, 32'h80000000},
                            {32'h80000000, 32'h0}, {32'h5, 32'h0}};
    int cyc; bit gap;
    for (int i = 0; i < 4; i++) begin
      launch(ta[i], tb[i], ts[i]);
      wait_ready(1, cyc, gap);
      checks++; if (result !== te[i]) begin
        errors++; $display("FAIL extreme[%0d]_result got=%h want=%h", i, result, te[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] ta [3] = '{32'h1234, 32'h1234, 32'hFFFFFFF9};
    logic        ts [3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] te [3] = '{{32'h1234, 32'hFFFFFFFF}, {32'h1234, 32'hFFFFFFFF},
                            {32'hFFFFFFF9, 32'hFFFFFFFF}};
    int cyc; bit gap;
    for (int i = 0; i < 3; i++) begin
      launch(ta[i], 32'h0, ts[i]);
      wait_ready(1, cyc, gap);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL divzero[%0d]_cycle got=%0d want=1", i, cyc); end
      checks++; if (result !== te[i]) begin
        errors++; $display("FAIL divzero[%0d]_result got=%h want=%h", i, result, te[i]);
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divzero[%0d]_idle2 got=%b want=0", i, busy); end
    end
  endtask

  task automatic test_back_to_back;
    int cyc; bit gap;
    launch(32'hFFFFFFFF, 32'h10, 1'b0);
    wait_ready(1, cyc, gap);
    checks++; if (result !== {32'hF, 32'h0FFFFFFF}) begin
      errors++; $display("FAIL b2b_first got=%h want=%h", result, {32'hF, 32'h0FFFFFFF});
    end
    // Next launch lands in cycle 34, the first IDLE cycle.
    launch(32'd100, 32'd7, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b want=1", busy); end
    wait_ready(1, cyc, gap);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_cycle got=%0d want=33", cyc); end
    checks++; if (result !== {32'h2, 32'hE}) begin
      errors++; $display("FAIL b2b_second got=%h want=%h", result, {32'h2, 32'hE});
    end
  endtask

  task automatic test_start_busy;
    int cyc; bit gap;
    launch(32'd100, 32'd7, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; a = 32'd1; b = 32'd0; signed_div = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_ready(6, cyc, gap);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL busy_start_cycle got=%0d want=33", cyc); end
    checks++; if (result !== {32'h2, 32'hE}) begin
      errors++; $display("FAIL busy_start_result got=%h want=%h", result, {32'h2, 32'hE});
    end
  endtask

  task automatic test_annul;
    bit saw_ready;
    launch(32'h12345678, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL annul_busy11 got=%b want=0", busy); end
    saw_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready) saw_ready = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_ready !== 1'b0) begin errors++; $display("FAIL annul_no_ready got=%b want=0", saw_ready); end
    checks++; if (result !== {32'h2, 32'hE}) begin
      errors++; $display("FAIL annul_result_kept got=%h want=%h", result, {32'h2, 32'hE});
    end
    // Annul wins over start in IDLE.
    start = 1'b1; annul = 1'b1; a = 32'd9; b = 32'd0;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    checks++; if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL annul_idle got busy=%b ready=%b want 0 0", busy, ready);
    end
  endtask

  task automatic test_reset_mid;
    int cyc; bit gap;
    launch(32'h1000, 32'd3, 1'b0);
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags got busy=%b ready=%b want 0 0", busy, ready);
    end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL rst_mid_result got=%h want=0", result); end
    @(negedge clk);
    rst = 1'b0;
    launch(32'd1000, 32'd10, 1'b0);
    wait_ready(1, cyc, gap);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL rst_after_cycle got=%0d want=33", cyc); end
    checks++; if (result !== {32'h0, 32'h64}) begin
      errors++; $display("FAIL rst_after_result got=%h want=%h", result, {32'h0, 32'h64});
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_extremes();
    test_div_zero();
    test_back_to_back();
    test_start_busy();
    test_annul();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
